axi_tlp_req_maker: RTL and testbench

Parametrised AXI4 address-channel to PCIe request-TLP header generator; one instance per address channel (AW → MWr, AR → MRd). Accepts one AXI burst, splits it into TLP-legal chunks bounded by the max payload (or read request) size and 4 KB boundaries, and pushes one 128-bit 4DW header per chunk into the downstream header FIFO. It sits between the AXI slave port and the TLP assembler.

---
 rtl/axi_tlp_req_maker_pkg.sv | 20 ++
 rtl/axi_tlp_req_maker_chunk_calc.sv | 17 +
 rtl/axi_tlp_req_maker.sv | 69 ++++++
 tb/tb_axi_tlp_req_maker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_tlp_req_maker_pkg.sv
// axi_tlp_req_maker_pkg: TLP header constants and memory-request header builder
package axi_tlp_req_maker_pkg;
  localparam int ADDR_WIDTH = 64;
  localparam logic [2:0] TLP_FMT_MWR4DW = 3'b011;
  localparam logic [2:0] TLP_FMT_MRD4DW = 3'b001;
  localparam logic [4:0] TLP_TYPE_MEM = 5'b00000;
  typedef enum logic {ST_IDLE, ST_EMIT} state_t;
  function automatic logic [127:0] make_mem_req_hdr(
    input logic [2:0]  fmt,
    input logic [63:0] addr,
    input logic [10:0] len_dw,
    input logic [15:0] req_id,
    input logic [7:0]  tag
  );
    logic [31:0] dw0, dw1;
    dw0 = {fmt, TLP_TYPE_MEM, 14'd0, len_dw[9:0]};
    dw1 = {req_id, tag, (len_dw > 11'd1) ? 4'hF : 4'h0, 4'hF};
    return {addr[31:0] & 32'hFFFF_FFFC, addr[63:32], dw1, dw0};
  endfunction
endpackage

// File: rtl/axi_tlp_req_maker_chunk_calc.sv
// tlp_chunk_calc: size of next TLP chunk, bounded by remaining bytes and the next chunk-aligned boundary
module tlp_chunk_calc #(
  parameter int MAX_CHUNK_BYTES = 128,
  parameter int CW = $clog2(MAX_CHUNK_BYTES)
) (
  input  logic [CW-1:0] addr_lo,
  input  logic [13:0]   remaining,
  output logic [12:0]   chunk,
  output logic          last
);
  logic [12:0] room;
  always_comb begin
    room = 13'(MAX_CHUNK_BYTES) - 13'(addr_lo);
    last = remaining <= {1'b0, room};
    chunk = last ? remaining[12:0] : room;
  end
endmodule

// File: rtl/axi_tlp_req_maker.sv
// axi_tlp_req_maker: splits one AXI burst into boundary-legal PCIe memory request headers
module axi_tlp_req_maker
  import axi_tlp_req_maker_pkg::*;
#(
  parameter int              MODE            = 0,
  parameter int              ADDR_WIDTH      = axi_tlp_req_maker_pkg::ADDR_WIDTH,
  parameter int              BEAT_BYTES      = 32,
  parameter int              MAX_CHUNK_BYTES = 128,
  parameter logic [15:0]     REQUESTER_ID    = 16'h0100,
  parameter int              TAG_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_avalid,
  output logic                  a_aready,
  input  logic [ADDR_WIDTH-1:0] a_aaddr,
  input  logic [7:0]            a_alen,
  input  logic                  hdr_fifo_afull,
  output logic                  hdr_fifo_wren,
  output logic [127:0]          hdr_fifo_data,
  output logic                  busy
);
  localparam int CW = $clog2(MAX_CHUNK_BYTES);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [13:0] remaining;
  logic [TAG_WIDTH-1:0] tag;
  logic [12:0] chunk;
  logic last, accept, emit;
  logic [127:0] hdr;
  tlp_chunk_calc #(.MAX_CHUNK_BYTES(MAX_CHUNK_BYTES)) u_calc (
    .addr_lo(cur_addr[CW-1:0]),
    .remaining(remaining),
    .chunk(chunk),
    .last(last)
  );
  always_comb begin
    a_aready = state == ST_IDLE;
    busy = state == ST_EMIT;
    accept = a_aready && a_avalid;
    emit = busy && !hdr_fifo_afull;
    state_nx = (state == ST_IDLE) ? (a_avalid ? ST_EMIT : ST_IDLE)
                                  : ((emit && last) ? ST_IDLE : ST_EMIT);
    hdr = make_mem_req_hdr((MODE != 0) ? TLP_FMT_MRD4DW : TLP_FMT_MWR4DW, 64'(cur_addr),
                           chunk[12:2], REQUESTER_ID, (MODE != 0) ? 8'(tag) : 8'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hdr_fifo_wren <= 1'b0;
      hdr_fifo_data <= '0;
      tag <= '0;
      cur_addr <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      hdr_fifo_wren <= emit;
      if (emit) begin
        hdr_fifo_data <= hdr;
        cur_addr <= cur_addr + ADDR_WIDTH'(chunk);
        remaining <= remaining - 14'(chunk);
        if (MODE != 0) tag <= tag + TAG_WIDTH'(1);
      end else if (accept) begin
        cur_addr <= a_aaddr & ~ADDR_WIDTH'(3);
        remaining <= (14'(a_alen) + 14'd1) * 14'(BEAT_BYTES);
      end
    end
  end
endmodule

// File: tb/tb_axi_tlp_req_maker.sv
// tb_axi_tlp_req_maker: vector table plus random bursts against a chunk-splitting scoreboard
module tb_axi_tlp_req_maker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic avalid[3];
  logic [63:0] aaddr[3];
  logic [7:0] alen_s[3];
  logic afull[3];
  logic aready[3], wren[3], busy[3];
  logic [127:0] data[3];
  int n_tests = 0;
  int n_fail = 0;
  int model_tag = 0;
  int got_n = 0;
  logic [127:0] got_first, got_last;
  typedef struct { int inst; logic [127:0] hdr; } exp_t;
  exp_t exp_q[$];
  typedef struct {
    int inst; logic [63:0] addr; int alen; int n;
    logic [31:0] dw0, dw1, dw3f, dw3l;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  axi_tlp_req_maker #(.MODE(0), .MAX_CHUNK_BYTES(128)) u_wr (
    .clk(clk), .rst_n(rst_n), .a_avalid(avalid[0]), .a_aready(aready[0]), .a_aaddr(aaddr[0]),
    .a_alen(alen_s[0]), .hdr_fifo_afull(afull[0]), .hdr_fifo_wren(wren[0]),
    .hdr_fifo_data(data[0]), .busy(busy[0]));
  axi_tlp_req_maker #(.MODE(0), .MAX_CHUNK_BYTES(4096)) u_w4k (
    .clk(clk), .rst_n(rst_n), .a_avalid(avalid[1]), .a_aready(aready[1]), .a_aaddr(aaddr[1]),
    .a_alen(alen_s[1]), .hdr_fifo_afull(afull[1]), .hdr_fifo_wren(wren[1]),
    .hdr_fifo_data(data[1]), .busy(busy[1]));
  axi_tlp_req_maker #(.MODE(1), .MAX_CHUNK_BYTES(128)) u_rd (
    .clk(clk), .rst_n(rst_n), .a_avalid(avalid[2]), .a_aready(aready[2]), .a_aaddr(aaddr[2]),
    .a_alen(alen_s[2]), .hdr_fifo_afull(afull[2]), .hdr_fifo_wren(wren[2]),
    .hdr_fifo_data(data[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: walk the burst byte range, cutting at every MAX_CHUNK-aligned address
  function automatic void push_burst(input int i, input logic [63:0] addr_in, input int len);
    logic [63:0] a;
    int rem, c, mc;
    logic [31:0] dw0, dw1;
    exp_t e;
    a = {addr_in[63:2], 2'b00};
    rem = (len + 1) * 32;
    mc = (i == 1) ? 4096 : 128;
    while (rem > 0) begin
      c = mc - int'(a % 64'(mc));
      if (rem < c) c = rem;
      dw0 = ((i == 2) ? 32'h2000_0000 : 32'h6000_0000) | 32'((c / 4) % 1024);
      dw1 = 32'h0100_000F | ((i == 2) ? 32'(model_tag << 8) : 32'h0) | ((c / 4 > 1) ? 32'hF0 : 32'h0);
      e.inst = i;
      e.hdr = {a[31:0], a[63:32], dw1, dw0};
      exp_q.push_back(e);
      a += 64'(c);
      rem -= c;
      if (i == 2) model_tag = (model_tag + 1) % 256;
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wren[i]) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_hdr inst %0d got %h expected none", i, data[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.inst != i || e.hdr !== data[i]) begin
            n_fail++;
            $display("FAIL hdr inst %0d got %h expected inst %0d %h", i, data[i], e.inst, e.hdr);
          end
        end
        if (got_n == 0) got_first = data[i];
        got_last = data[i];
        got_n++;
      end
      if (busy[i]) begin
        n_tests++;
        if (aready[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL aready_busy inst %0d got %b expected 0", i, aready[i]);
        end
      end
    end
  end

  task automatic wait_idle(input int i, input bit rnd);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) afull[i] = ($urandom_range(0, 3) == 0);
      k++;
    end while ((busy[i] || exp_q.size() != 0) && k < 3000);
    afull[i] = 1'b0;
    chk("drain_timeout", 128'(k >= 3000), 128'(0));
  endtask

  task automatic handshake(input int i, input logic [63:0] addr, input int len);
    push_burst(i, addr, len);
    got_n = 0;
    @(posedge clk); #1;
    chk("aready_idle", 128'(aready[i]), 128'(1));
    avalid[i] = 1'b1;
    aaddr[i] = addr;
    alen_s[i] = 8'(len);
    @(posedge clk); #1;
    avalid[i] = 1'b0;
    chk("busy_after_hs", 128'(busy[i]), 128'(1));
    chk("no_early_wren", 128'(wren[i]), 128'(0));
  endtask

  task automatic send(input int i, input logic [63:0] addr, input int len, input bit rnd);
    handshake(i, addr, len);
    if (!rnd) begin
      @(posedge clk); #1;
      chk("first_wren", 128'(wren[i]), 128'(1));
    end
    wait_idle(i, rnd);
  endtask

  task automatic run_row(input int k);
    send(tbl[k].inst, tbl[k].addr, tbl[k].alen, 1'b0);
    chk("row_count", 128'(got_n), 128'(tbl[k].n));
    chk("row_dw0", 128'(got_first[31:0]), 128'(tbl[k].dw0));
    chk("row_dw1", 128'(got_first[63:32]), 128'(tbl[k].dw1));
    chk("row_dw3_first", 128'(got_first[127:96]), 128'(tbl[k].dw3f));
    chk("row_dw3_last", 128'(got_last[127:96]), 128'(tbl[k].dw3l));
  endtask

  initial begin
    tbl[0] = '{0, 64'h1000, 3,   1, 32'h6000_0020, 32'h0100_00FF, 32'h1000, 32'h1000};
    tbl[1] = '{0, 64'h1040, 7,   3, 32'h6000_0010, 32'h0100_00FF, 32'h1040, 32'h1100};
    tbl[2] = '{1, 64'h0FE0, 1,   2, 32'h6000_0008, 32'h0100_00FF, 32'h0FE0, 32'h1000};
    tbl[3] = '{2, 64'h2000, 0,   1, 32'h2000_0008, 32'h0100_FEFF, 32'h2000, 32'h2000};
    tbl[4] = '{2, 64'h2003, 0,   1, 32'h2000_0008, 32'h0100_FFFF, 32'h2000, 32'h2000};
    tbl[5] = '{2, 64'h3000, 0,   1, 32'h2000_0008, 32'h0100_00FF, 32'h3000, 32'h3000};
    tbl[6] = '{0, 64'h1004, 0,   1, 32'h6000_0008, 32'h0100_00FF, 32'h1004, 32'h1004};
    tbl[7] = '{1, 64'h0000, 255, 2, 32'h6000_0000, 32'h0100_00FF, 32'h0000, 32'h1000};
    tbl[8] = '{0, 64'h007C, 0,   2, 32'h6000_0001, 32'h0100_000F, 32'h007C, 32'h0080};
    for (int i = 0; i < 3; i++) begin
      avalid[i] = 1'b0; aaddr[i] = '0; alen_s[i] = '0; afull[i] = 1'b0;
    end
    #23;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wren", 128'(wren[i]), 128'(0));
      chk("rst_data", data[i], 128'(0));
      chk("rst_busy", 128'(busy[i]), 128'(0));
      chk("rst_aready", 128'(aready[i]), 128'(1));
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) run_row(k);
    for (int k = 0; k < 254; k++) send(2, 64'(k * 64), 0, 1'b0);
    for (int k = 3; k < 9; k++) run_row(k);
    // Back-pressure mid-burst: four-chunk burst stalled after its first header
    handshake(0, 64'h0, 15);
    @(posedge clk); #1;
    afull[0] = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk); #1;
      chk("afull_no_wren", 128'(wren[0]), 128'(0));
      chk("afull_busy", 128'(busy[0]), 128'(1));
      @(posedge clk);
    end
    #1 afull[0] = 1'b0;
    wait_idle(0, 1'b0);
    chk("afull_count", 128'(got_n), 128'(4));
    for (int k = 0; k < 40; k++) begin
      int i, len;
      i = $urandom_range(0, 2);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      send(i, {$urandom(), $urandom()}, len, 1'b1);
    end
    // Reset while the second of three read chunks is on the output
    handshake(2, 64'h0, 11);
    @(posedge clk);
    @(posedge clk); #6;
    chk("hdrs_before_rst", 128'(got_n), 128'(2));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wren", 128'(wren[2]), 128'(0));
    chk("rst_mid_busy", 128'(busy[2]), 128'(0));
    chk("rst_mid_data", data[2], 128'(0));
    chk("dropped_hdrs", 128'(exp_q.size()), 128'(1));
    exp_q.delete();
    model_tag = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    send(2, 64'h4000, 0, 1'b0);
    chk("tag_after_rst", 128'(got_first[47:40]), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
